// File: rtl/cross_bar_pkg.sv
// Shared crossbar constants and types used by the per-slave arbiters
// and the master-side response logic.
package cross_bar_pkg;

  localparam int MASTER_N        = 4;
  localparam int SLAVE_N         = 4;
  localparam int ARB_TIMEOUT_DEF = 256;
  localparam int MASTER_ID_W     = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [MASTER_ID_W-1:0] master_id_t;

endpackage : cross_bar_pkg

// File: rtl/cross_bar_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of i_elig at
// or above i_ptr, wrapping back to bit 0. Shared by slave- and master-side
// arbiters.
module cross_bar_rr_pick #(
  parameter int N = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   i_elig,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_onehot,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin : pick
    int v_k;
    v_k      = 0;
    o_onehot = {N{1'b0}};
    o_idx    = {IDW{1'b0}};
    o_any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      v_k = int'(i_ptr) + i;
      if (v_k >= N) begin
        v_k = v_k - N;
      end else begin
        v_k = v_k;
      end
      if (!o_any && i_elig[v_k]) begin
        o_any         = 1'b1;
        o_onehot[v_k] = 1'b1;
        o_idx         = IDW'(v_k);
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule : cross_bar_rr_pick

// File: rtl/cross_bar_slave_arb.sv
// Per-slave-port round-robin arbiter. Grants one master at a time, holds
// the grant until the slave acks, and returns the ack to that master.
// A blocked mask keeps a just-served request from being re-granted until
// the master has visibly dropped it for at least one cycle.
// Optional watchdog: define CROSS_BAR_ARB_TIMEOUT_EN to abort a grant that
// sees no ack within TIMEOUT_CYC busy cycles.
module cross_bar_slave_arb
  import cross_bar_pkg::*;
#(
  parameter int N_REQ       = MASTER_N,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [N_REQ-1:0] req,
  input  logic             slave_ack,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             grant_vld,
  output logic [N_REQ-1:0] req_ack,
  output logic             timeout_err
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [IDW-1:0]   r_grant_id;
  logic             r_grant_vld;
  logic [IDW-1:0]   r_ptr;
  logic [N_REQ-1:0] r_blocked;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_pick_oh;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_any;
  logic             w_ack_hit;
  logic             w_timeout;
  logic             w_release;
  logic [IDW-1:0]   w_ptr_inc;

  assign w_elig = req & ~r_blocked;

  cross_bar_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Pointer moves to the master just after the one being released.
  assign w_ptr_inc = (r_grant_id == IDW'(N_REQ - 1)) ? {IDW{1'b0}}
                                                     : (r_grant_id + {{(IDW-1){1'b0}}, 1'b1});

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;

  // Watchdog: zero outside BUSY, counts busy cycles that see no ack.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_state != BUSY || w_release) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // An ack in the expiring cycle takes precedence over the timeout.
  assign w_timeout = (r_state == BUSY) && !slave_ack &&
                     (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: grant on any eligible request, release on ack/timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: ack routing and release strobe; ack outside BUSY is ignored.
  always_comb begin
    w_ack_hit = 1'b0;
    if (r_state == BUSY) begin
      w_ack_hit = slave_ack;
    end else begin
      w_ack_hit = 1'b0;
    end
    w_release   = w_ack_hit | w_timeout;
    req_ack     = r_grant & {N_REQ{w_ack_hit}};
    timeout_err = w_timeout;
  end

  // Grant registers: load on pick in IDLE, clear on release, else hold.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant     <= {N_REQ{1'b0}};
      r_grant_id  <= {IDW{1'b0}};
      r_grant_vld <= 1'b0;
      r_ptr       <= {IDW{1'b0}};
    end else if (r_state == IDLE && w_pick_any) begin
      r_grant     <= w_pick_oh;
      r_grant_id  <= w_pick_idx;
      r_grant_vld <= 1'b1;
    end else if (r_state == BUSY && w_release) begin
      r_grant     <= {N_REQ{1'b0}};
      r_grant_id  <= {IDW{1'b0}};
      r_grant_vld <= 1'b0;
      r_ptr       <= w_ptr_inc;
    end else begin
      r_grant     <= r_grant;
      r_grant_id  <= r_grant_id;
      r_grant_vld <= r_grant_vld;
      r_ptr       <= r_ptr;
    end
  end

  // Blocked mask: cleared where req is low, set for the released master (set wins).
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_blocked <= {N_REQ{1'b0}};
    end else if (r_state == BUSY && w_release) begin
      r_blocked <= (r_blocked & req) | r_grant;
    end else begin
      r_blocked <= r_blocked & req;
    end
  end

  assign grant     = r_grant;
  assign grant_id  = r_grant_id;
  assign grant_vld = r_grant_vld;

endmodule : cross_bar_slave_arb
